// File: rtl/sprite_mem_arbiter.sv
// Arbiter for the single-port sprite memory shared by the CPU pipeline (read/write)
// and the GPU render engine (read-only). The CPU normally wins. A GPU burst is
// bounded so that a pending CPU access waits at most GPU_BURST cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no grant last cycle; CPU wins a tie
// CPU    | last grant went to the CPU; a waiting GPU goes next
// GPU    | last grant went to the GPU; burst_cnt counts consecutive GPU grants
module sprite_mem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int FIELD_W   = 4,
   parameter int DATA_W    = 32,
   parameter int GPU_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [ADDR_W-1:0]         cpu_addr,
   input  logic [FIELD_W-1:0]        cpu_field,
   input  logic [DATA_W-1:0]         cpu_wdata,
   output logic                      cpu_gnt,
   output logic                      cpu_rvalid,
   output logic [DATA_W-1:0]         cpu_rdata,
   output logic                      stall,
   input  logic                      gpu_req,
   input  logic [ADDR_W-1:0]         gpu_addr,
   input  logic [FIELD_W-1:0]        gpu_field,
   output logic                      gpu_gnt,
   output logic                      gpu_rvalid,
   output logic [DATA_W-1:0]         gpu_rdata,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W+FIELD_W-1:0] mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int CNT_W = $clog2(GPU_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(GPU_BURST);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CPU  = 2'd1;
   localparam logic [1:0] S_GPU  = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_nxt;
   logic             pick_cpu, pick_gpu;
   logic             cpu_rvalid_q, gpu_rvalid_q;

   // Pick this cycle's winner from the registered state and live requests.
   always_comb begin
      pick_cpu = 1'b0;
      pick_gpu = 1'b0;
      case (state)
         S_CPU: begin
            if (gpu_req)      pick_gpu = 1'b1;
            else if (cpu_req) pick_cpu = 1'b1;
         end
         S_GPU: begin
            if (cpu_req && burst_cnt == BURST_MAX) pick_cpu = 1'b1;
            else if (gpu_req)                      pick_gpu = 1'b1;
            else if (cpu_req)                      pick_cpu = 1'b1;
         end
         default: begin
            if (cpu_req)      pick_cpu = 1'b1;
            else if (gpu_req) pick_gpu = 1'b1;
         end
      endcase
   end

   // Next state follows the winner; the burst count only grows across GPU-to-GPU grants.
   always_comb begin
      state_nxt = S_IDLE;
      burst_nxt = '0;
      if (pick_cpu) begin
         state_nxt = S_CPU;
      end else if (pick_gpu) begin
         state_nxt = S_GPU;
         if (state == S_GPU)
            burst_nxt = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
         else
            burst_nxt = CNT_W'(1);
      end
   end

   // State, burst counter and read-return flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         burst_cnt    <= '0;
         cpu_rvalid_q <= 1'b0;
         gpu_rvalid_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         burst_cnt    <= burst_nxt;
         cpu_rvalid_q <= cpu_gnt & ~cpu_we;
         gpu_rvalid_q <= gpu_gnt;
      end
   end

   // Grants and stall are masked by reset so every output reads 0 while rst_n is low.
   assign cpu_gnt = rst_n & pick_cpu;
   assign gpu_gnt = rst_n & pick_gpu;
   assign stall   = rst_n & ((cpu_req & ~cpu_gnt) | (cpu_gnt & ~cpu_we));

   assign mem_en    = cpu_gnt | gpu_gnt;
   assign mem_we    = cpu_gnt & cpu_we;
   assign mem_addr  = cpu_gnt ? {cpu_addr, cpu_field} :
                      gpu_gnt ? {gpu_addr, gpu_field} : '0;
   assign mem_wdata = mem_we ? cpu_wdata : '0;

   assign cpu_rvalid = cpu_rvalid_q;
   assign gpu_rvalid = gpu_rvalid_q;
   assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
   assign gpu_rdata  = gpu_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: behavioural sprite memory, a reference copy of its
// contents, and per-requester queues of expected read data checked on each rvalid.
module tb_sprite_mem_arbiter;

   localparam int AW = 8;
   localparam int FW = 4;
   localparam int DW = 32;
   localparam int BURST = 4;
   localparam int MW = AW + FW;
   localparam int OUT_W = 3*DW + MW + 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [FW-1:0] cpu_field;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid, stall;
   logic [DW-1:0] cpu_rdata;
   logic          gpu_req;
   logic [AW-1:0] gpu_addr;
   logic [FW-1:0] gpu_field;
   logic          gpu_gnt, gpu_rvalid;
   logic [DW-1:0] gpu_rdata;
   logic          mem_en, mem_we;
   logic [MW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem_arr [0:(1<<MW)-1];
   logic [DW-1:0] ref_mem [0:(1<<MW)-1];
   logic [DW-1:0] cpu_q [$];
   logic [DW-1:0] gpu_q [$];
   logic [OUT_W-1:0] all_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sprite_mem_arbiter #(
      .ADDR_W(AW), .FIELD_W(FW), .DATA_W(DW), .GPU_BURST(BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_field(cpu_field),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .stall(stall),
      .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_field(gpu_field),
      .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   assign all_out = {cpu_gnt, cpu_rvalid, cpu_rdata, stall, gpu_gnt, gpu_rvalid,
                     gpu_rdata, mem_en, mem_we, mem_addr, mem_wdata};

   // Single-port memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   // Scoreboard: check returning data first, then record new grants.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cpu_rvalid) begin
            total++;
            if (cpu_q.size() == 0) begin
               bad++;
               $display("FAIL cpu_rvalid_unexpected rdata=%h", cpu_rdata);
            end else begin
               logic [DW-1:0] e;
               e = cpu_q.pop_front();
               if (cpu_rdata !== e) begin
                  bad++;
                  $display("FAIL cpu_rdata got=%h want=%h", cpu_rdata, e);
               end
            end
         end else begin
            total++;
            if (cpu_rdata !== '0) begin
               bad++;
               $display("FAIL cpu_rdata_idle got=%h want=0", cpu_rdata);
            end
         end
         if (gpu_rvalid) begin
            total++;
            if (gpu_q.size() == 0) begin
               bad++;
               $display("FAIL gpu_rvalid_unexpected rdata=%h", gpu_rdata);
            end else begin
               logic [DW-1:0] e;
               e = gpu_q.pop_front();
               if (gpu_rdata !== e) begin
                  bad++;
                  $display("FAIL gpu_rdata got=%h want=%h", gpu_rdata, e);
               end
            end
         end
         if (cpu_gnt && cpu_we)  ref_mem[{cpu_addr, cpu_field}] = cpu_wdata;
         if (cpu_gnt && !cpu_we) cpu_q.push_back(ref_mem[{cpu_addr, cpu_field}]);
         if (gpu_gnt)            gpu_q.push_back(ref_mem[{gpu_addr, gpu_field}]);
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_and_drain(input string name);
      repeat (3) drive_edge();
      total++;
      if (cpu_q.size() != 0 || gpu_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain cpu_pending=%0d gpu_pending=%0d want=0/0", name, cpu_q.size(), gpu_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05; cpu_field = 4'h1; cpu_wdata = '0;
      gpu_req = 1'b1; gpu_addr = 8'h06; gpu_field = 4'h2;
      @(negedge clk);
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", all_out);
      end
      drive_edge();
      cpu_req = 1'b0; gpu_req = 1'b0;
      rst_n = 1'b1;
      drive_edge();
      cpu_req = 1'b1;
      @(negedge clk);
      total++;
      if (cpu_gnt !== 1'b1 || stall !== 1'b1) begin
         bad++;
         $display("FAIL reset_preread gnt=%b stall=%b want=1/1", cpu_gnt, stall);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset_midread got=%h want=0", all_out);
      end
      cpu_q.delete();
      gpu_q.delete();
      drive_edge();
      cpu_req = 1'b0;
      drive_edge();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (cpu_rvalid !== 1'b0 || gpu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_rvalid cpu=%b gpu=%b want=0/0", cpu_rvalid, gpu_rvalid);
         end
      end
      settle_and_drain("reset");
   endtask

   task automatic test_write_read();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_field = 4'h3;
      cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      total++;
      if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h123 ||
          mem_wdata !== 32'hDEADBEEF || stall !== 1'b0) begin
         bad++;
         $display("FAIL write_grant gnt=%b en=%b we=%b addr=%h wdata=%h stall=%b want=1/1/1/123/deadbeef/0",
                  cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata, stall);
      end
      drive_edge();
      cpu_we = 1'b0; cpu_wdata = '0;
      @(negedge clk);
      total++;
      if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h123 || stall !== 1'b1 ||
          cpu_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL read_grant gnt=%b we=%b addr=%h stall=%b rvalid=%b want=1/0/123/1/0",
                  cpu_gnt, mem_we, mem_addr, stall, cpu_rvalid);
      end
      drive_edge();
      cpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || stall !== 1'b0) begin
         bad++;
         $display("FAIL read_return rvalid=%b rdata=%h stall=%b want=1/deadbeef/0",
                  cpu_rvalid, cpu_rdata, stall);
      end
      settle_and_drain("write_read");
   endtask

   task automatic test_simultaneous();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20; cpu_field = 4'h1;
      gpu_req = 1'b1; gpu_addr = 8'h30; gpu_field = 4'h2;
      @(negedge clk);
      total++;
      if (cpu_gnt !== 1'b1 || gpu_gnt !== 1'b0) begin
         bad++;
         $display("FAIL tie_cycle0 cpu_gnt=%b gpu_gnt=%b want=1/0", cpu_gnt, gpu_gnt);
      end
      drive_edge();
      cpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (gpu_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b1 || mem_addr !== 12'h302) begin
         bad++;
         $display("FAIL tie_cycle1 gpu_gnt=%b cpu_gnt=%b cpu_rvalid=%b addr=%h want=1/0/1/302",
                  gpu_gnt, cpu_gnt, cpu_rvalid, mem_addr);
      end
      drive_edge();
      gpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (gpu_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL tie_cycle2 gpu_rvalid=%b cpu_rvalid=%b want=1/0", gpu_rvalid, cpu_rvalid);
      end
      settle_and_drain("simultaneous");
   endtask

   task automatic test_burst();
      gpu_req = 1'b1; gpu_addr = 8'h40; gpu_field = 4'h0;
      @(negedge clk);
      total++;
      if (gpu_gnt !== 1'b1) begin
         bad++;
         $display("FAIL burst_first gpu_gnt=%b want=1", gpu_gnt);
      end
      drive_edge();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50; cpu_field = 4'h7;
      for (int i = 0; i < BURST - 1; i++) begin
         gpu_field = 4'(i + 1);
         @(negedge clk);
         total++;
         if (gpu_gnt !== 1'b1 || cpu_gnt !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL burst_gpu%0d gpu_gnt=%b cpu_gnt=%b stall=%b want=1/0/1",
                     i, gpu_gnt, cpu_gnt, stall);
         end
         drive_edge();
      end
      @(negedge clk);
      total++;
      if (cpu_gnt !== 1'b1 || gpu_gnt !== 1'b0 || stall !== 1'b1 || mem_addr !== 12'h507) begin
         bad++;
         $display("FAIL burst_cpu cpu_gnt=%b gpu_gnt=%b stall=%b addr=%h want=1/0/1/507",
                  cpu_gnt, gpu_gnt, stall, mem_addr);
      end
      drive_edge();
      cpu_req = 1'b0; gpu_req = 1'b0;
      settle_and_drain("burst");
   endtask

   task automatic test_alternate();
      logic got_c, got_g, exp_c;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h60; cpu_field = 4'h0;
      gpu_req = 1'b1; gpu_addr = 8'h70; gpu_field = 4'h0;
      for (int i = 0; i < 12; i++) begin
         exp_c = (i % (BURST + 1)) == 0;
         @(negedge clk);
         got_c = cpu_gnt;
         got_g = gpu_gnt;
         total++;
         if (got_c !== exp_c || got_g !== !exp_c || stall !== 1'b1) begin
            bad++;
            $display("FAIL alternate_cycle%0d cpu_gnt=%b gpu_gnt=%b stall=%b want=%b/%b/1",
                     i, got_c, got_g, stall, exp_c, !exp_c);
         end
         drive_edge();
         if (got_c) cpu_field = cpu_field + 4'h1;
         if (got_g) gpu_field = gpu_field + 4'h1;
      end
      cpu_req = 1'b0; gpu_req = 1'b0;
      settle_and_drain("alternate");
   endtask

   task automatic test_back_to_back();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h81; cpu_field = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (cpu_gnt !== 1'b1 || stall !== 1'b1 || cpu_rvalid !== (i != 0)) begin
            bad++;
            $display("FAIL b2b_read%0d gnt=%b stall=%b rvalid=%b want=1/1/%b",
                     i, cpu_gnt, stall, cpu_rvalid, i != 0);
         end
         drive_edge();
         cpu_field = cpu_field + 4'h5;
      end
      cpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b1 || stall !== 1'b0) begin
         bad++;
         $display("FAIL b2b_last rvalid=%b stall=%b want=1/0", cpu_rvalid, stall);
      end
      settle_and_drain("back_to_back");
   endtask

   task automatic test_gpu_idle();
      gpu_req = 1'b1; gpu_addr = 8'h90; gpu_field = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (gpu_gnt !== 1'b1) begin
            bad++;
            $display("FAIL gpu_only%0d gpu_gnt=%b want=1", i, gpu_gnt);
         end
         drive_edge();
         gpu_field = gpu_field + 4'h1;
      end
      gpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (mem_en !== 1'b0 || gpu_gnt !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL gpu_drop en=%b gnt=%b addr=%h we=%b want=0/0/0/0", mem_en, gpu_gnt, mem_addr, mem_we);
      end
      drive_edge();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hA0; cpu_field = 4'h4;
      gpu_req = 1'b1; gpu_addr = 8'hA1;
      @(negedge clk);
      total++;
      if (cpu_gnt !== 1'b1 || gpu_gnt !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_gpu cpu_gnt=%b gpu_gnt=%b want=1/0", cpu_gnt, gpu_gnt);
      end
      drive_edge();
      cpu_req = 1'b0;
      @(negedge clk);
      total++;
      if (gpu_gnt !== 1'b1) begin
         bad++;
         $display("FAIL gpu_after_cpu gpu_gnt=%b want=1", gpu_gnt);
      end
      drive_edge();
      gpu_req = 1'b0;
      settle_and_drain("gpu_idle");
   endtask

   initial begin
      for (int i = 0; i < (1 << MW); i++) begin
         mem_arr[i] = 32'hA5000000 ^ (i * 32'h00010001);
         ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010001);
      end
      mem_rdata = '0;
      test_reset();
      test_write_read();
      test_simultaneous();
      test_burst();
      test_alternate();
      test_back_to_back();
      test_gpu_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
